lcd_rgb_dither: RTL and testbench



---
 rtl/lcd_dither_pkg.sv | 40 ++++
 rtl/lcd_dither_channel.sv | 32 +++
 rtl/lcd_rgb_dither.sv | 152 +++++++++++++++
 tb/tb_lcd_rgb_dither.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lcd_dither_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_dither_pkg : Bayer matrix, pixel types and saturating add helper |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lcd_dither_pkg;

  localparam int SAT_W = 16;

  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_in_t;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb_out_t;

  // Rounding up never wraps: a channel already at full scale stays there.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] base,
                                               input logic             up,
                                               input logic [SAT_W-1:0] max_val);
    logic [SAT_W-1:0] result;
    result = base;
    if (up && (base != max_val)) result = base + 16'd1;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_dither_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_dither_channel : one colour channel, truncate + ordered round-up |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lcd_dither_channel
  import lcd_dither_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 6
) (
  input  logic [IN_BITS-1:0]  value,
  input  logic [3:0]          threshold,
  output logic [OUT_BITS-1:0] dithered
);

  localparam int               SHIFT   = IN_BITS - OUT_BITS;
  localparam logic [SAT_W-1:0] MAX_OUT = 16'((1 << OUT_BITS) - 1);

  logic [OUT_BITS-1:0] base;
  logic [3:0]          r4;
  logic                up;

  assign base = value[IN_BITS-1:SHIFT];
  // Residual scaled to a 4-bit range so it compares directly with the matrix.
  assign r4   = 4'(value[SHIFT-1:0]) << (4 - SHIFT);
  assign up   = (r4 > threshold);

  assign dithered = OUT_BITS'(sat_add(16'(base), up, MAX_OUT));

endmodule
`default_nettype wire

// File: rtl/lcd_rgb_dither.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_rgb_dither : 24-bit RGB to 6:6:6 LCD bus, 4x4 Bayer dither.       |
// | Optional LCD_DITHER_TEMPORAL_EN shifts the pattern every frame.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lcd_rgb_dither
  import lcd_dither_pkg::*;
#(
  parameter int IN_BITS          = 8,
  parameter int OUT_BITS         = 6,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic                 vid_clk,
  input  logic                 reset,
  input  logic [3*IN_BITS-1:0] in_data,
  input  logic                 in_datavalid,
  input  logic                 in_h_sync,
  input  logic                 in_v_sync,
  input  logic                 in_underflow,
  input  logic                 underflow_clr,
  output logic [OUT_BITS-1:0]  lcd_r,
  output logic [OUT_BITS-1:0]  lcd_g,
  output logic [OUT_BITS-1:0]  lcd_b,
  output logic                 lcd_de,
  output logic                 lcd_hs,
  output logic                 lcd_vs,
  output logic                 underflow_sticky
);

  localparam int   SHIFT     = IN_BITS - OUT_BITS;
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE_HIGH;

  if ((SHIFT < 1) || (SHIFT > 4)) begin : g_bad_shift
    $error("lcd_rgb_dither: IN_BITS-OUT_BITS must be in 1..4");
  end

  logic [1:0]           x_cnt;
  logic [1:0]           y_cnt;
  logic [1:0]           xi;
  logic [1:0]           yi;
  logic                 dv_fall;
  logic                 vs_start;
  logic [3*IN_BITS-1:0] s1_data;
  logic                 s1_de;
  logic                 s1_hs;
  logic                 s1_vs;
  logic [3:0]           s1_thr;
  logic [OUT_BITS-1:0]  dith_r;
  logic [OUT_BITS-1:0]  dith_g;
  logic [OUT_BITS-1:0]  dith_b;

  // Stage-1 DE and VS double as the previous-cycle samples for edge detection.
  assign dv_fall  = s1_de & ~in_datavalid;
  assign vs_start = (in_v_sync == SYNC_ACTIVE_HIGH) && (s1_vs != SYNC_ACTIVE_HIGH);

`ifdef LCD_DITHER_TEMPORAL_EN
  logic [1:0] frame_cnt;

  always_ff @(posedge vid_clk) begin
    if (reset) begin
      frame_cnt <= 2'd0;
    end else if (vs_start) begin
      frame_cnt <= frame_cnt + 2'd1;
    end
  end

  assign xi = x_cnt + frame_cnt;
  assign yi = y_cnt + frame_cnt;
`else
  assign xi = x_cnt;
  assign yi = y_cnt;
`endif

  always_ff @(posedge vid_clk) begin
    if (reset) begin
      x_cnt <= 2'd0;
      y_cnt <= 2'd0;
    end else begin
      x_cnt <= in_datavalid ? (x_cnt + 2'd1) : 2'd0;
      if (vs_start) begin
        y_cnt <= 2'd0;
      end else if (dv_fall) begin
        y_cnt <= y_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge vid_clk) begin
    if (reset) begin
      s1_data <= '0;
      s1_de   <= 1'b0;
      s1_hs   <= SYNC_IDLE;
      s1_vs   <= SYNC_IDLE;
      s1_thr  <= 4'd0;
    end else begin
      s1_data <= in_data;
      s1_de   <= in_datavalid;
      s1_hs   <= in_h_sync;
      s1_vs   <= in_v_sync;
      s1_thr  <= BAYER4[yi][xi];
    end
  end

  lcd_dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_ch_r (
    .value     (s1_data[3*IN_BITS-1:2*IN_BITS]),
    .threshold (s1_thr),
    .dithered  (dith_r)
  );

  lcd_dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_ch_g (
    .value     (s1_data[2*IN_BITS-1:IN_BITS]),
    .threshold (s1_thr),
    .dithered  (dith_g)
  );

  lcd_dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_ch_b (
    .value     (s1_data[IN_BITS-1:0]),
    .threshold (s1_thr),
    .dithered  (dith_b)
  );

  always_ff @(posedge vid_clk) begin
    if (reset) begin
      lcd_r  <= '0;
      lcd_g  <= '0;
      lcd_b  <= '0;
      lcd_de <= 1'b0;
      lcd_hs <= SYNC_IDLE;
      lcd_vs <= SYNC_IDLE;
    end else begin
      lcd_r  <= s1_de ? dith_r : '0;
      lcd_g  <= s1_de ? dith_g : '0;
      lcd_b  <= s1_de ? dith_b : '0;
      lcd_de <= s1_de;
      lcd_hs <= s1_hs;
      lcd_vs <= s1_vs;
    end
  end

  always_ff @(posedge vid_clk) begin
    if (reset) begin
      underflow_sticky <= 1'b0;
    end else if (in_underflow) begin
      underflow_sticky <= 1'b1;
    end else if (underflow_clr) begin
      underflow_sticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_rgb_dither.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_rgb_dither : directed checks of lcd_rgb_dither (default build) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lcd_rgb_dither;
  import lcd_dither_pkg::*;

  logic        vid_clk = 1'b0;
  logic        reset;
  logic [23:0] in_data;
  logic        in_datavalid;
  logic        in_h_sync;
  logic        in_v_sync;
  logic        in_underflow;
  logic        underflow_clr;
  logic [5:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [5:0]  lcd_b;
  logic        lcd_de;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        underflow_sticky;

  int n_checks = 0;
  int n_fails  = 0;

  localparam rgb_in_t    P81 = '{r: 8'h81, g: 8'h81, b: 8'h81};
  localparam rgb_in_t    PFF = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_in_t    P12 = '{r: 8'h12, g: 8'h34, b: 8'h56};
  localparam logic [17:0] O0  = 18'h0;
  localparam logic [17:0] O20 = {3{6'h20}};
  localparam logic [17:0] O21 = {3{6'h21}};
  localparam logic [17:0] O3F = {3{6'h3F}};

  logic [17:0] line_exp [8];

  always #5 vid_clk = ~vid_clk;

  lcd_rgb_dither dut (
    .vid_clk          (vid_clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_datavalid     (in_datavalid),
    .in_h_sync        (in_h_sync),
    .in_v_sync        (in_v_sync),
    .in_underflow     (in_underflow),
    .underflow_clr    (underflow_clr),
    .lcd_r            (lcd_r),
    .lcd_g            (lcd_g),
    .lcd_b            (lcd_b),
    .lcd_de           (lcd_de),
    .lcd_hs           (lcd_hs),
    .lcd_vs           (lcd_vs),
    .underflow_sticky (underflow_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then check the outputs produced by the previous step's input.
  task automatic step(input string tag, input logic [23:0] d, input logic dv,
                      input logic hs, input logic vs, input logic [17:0] e_rgb,
                      input logic e_de, input logic e_hs, input logic e_vs);
    in_data      = d;
    in_datavalid = dv;
    in_h_sync    = hs;
    in_v_sync    = vs;
    @(posedge vid_clk);
    #1;
    check({tag, ".rgb"}, 32'({lcd_r, lcd_g, lcd_b}), 32'(e_rgb));
    check({tag, ".de"},  32'(lcd_de), 32'(e_de));
    check({tag, ".hs"},  32'(lcd_hs), 32'(e_hs));
    check({tag, ".vs"},  32'(lcd_vs), 32'(e_vs));
  endtask

  initial begin
    reset         = 1'b1;
    in_data       = 24'h0;
    in_datavalid  = 1'b0;
    in_h_sync     = 1'b1;
    in_v_sync     = 1'b1;
    in_underflow  = 1'b0;
    underflow_clr = 1'b0;
    line_exp      = '{O21, O20, O21, O20, O21, O21, O20, O21};

    repeat (2) @(posedge vid_clk);
    #1;
    check("rst.rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(O0));
    check("rst.de", 32'(lcd_de), 32'd0);
    check("rst.hs", 32'(lcd_hs), 32'd1);
    check("rst.vs", 32'(lcd_vs), 32'd1);
    check("rst.sticky", 32'(underflow_sticky), 32'd0);
    reset = 1'b0;

    // Row 0 thresholds 0,8,2,10 against residual 4
    step("st0", P81, 1, 1, 1, O0,  0, 1, 1);
    step("st1", P81, 1, 1, 1, O21, 1, 1, 1);
    step("st2", P81, 1, 1, 1, O20, 1, 1, 1);
    step("st3", P81, 1, 1, 1, O21, 1, 1, 1);
    step("st4", 24'h0, 0, 1, 1, O20, 1, 1, 1);
    step("st5", 24'h0, 0, 1, 1, O0,  0, 1, 1);

    step("bl0", P12, 0, 0, 1, O0, 0, 1, 1);
    step("bl1", P12, 0, 1, 1, O0, 0, 0, 1);
    step("bl2", P12, 0, 1, 1, O0, 0, 1, 1);

    for (int ln = 0; ln < 4; ln++) begin
      for (int px = 0; px < 4; px++) begin
        step("sat", PFF, 1, 1, 1, (px == 0) ? O0 : O3F, (px != 0), 1, 1);
      end
      step("sat_gap", 24'h0, 0, 1, 1, O3F, 1, 1, 1);
    end

    step("vs0", 24'h0, 0, 1, 0, O0, 0, 1, 1);
    step("vs1", 24'h0, 0, 1, 1, O0, 0, 1, 0);

    // Lines at x=0: even rows round up, odd rows do not; line 4 ends on a v_sync edge
    for (int ln = 0; ln < 8; ln++) begin
      step($sformatf("ln%0d.px", ln), P81, 1, 1, 1, O0, 0, 1, (ln == 5) ? 1'b0 : 1'b1);
      step($sformatf("ln%0d.gap", ln), 24'h0, 0, 1, (ln == 4) ? 1'b0 : 1'b1,
           line_exp[ln], 1, 1, 1);
    end

    in_underflow  = 1'b1;
    underflow_clr = 1'b1;
    step("uf0", 24'h0, 0, 1, 1, O0, 0, 1, 1);
    check("uf.set_wins", 32'(underflow_sticky), 32'd1);
    in_underflow  = 1'b0;
    step("uf1", 24'h0, 0, 1, 1, O0, 0, 1, 1);
    check("uf.clear", 32'(underflow_sticky), 32'd0);
    in_underflow  = 1'b1;
    underflow_clr = 1'b0;
    step("uf2", 24'h0, 0, 1, 1, O0, 0, 1, 1);
    check("uf.set", 32'(underflow_sticky), 32'd1);
    in_underflow  = 1'b0;
    step("uf3", 24'h0, 0, 1, 1, O0, 0, 1, 1);
    check("uf.hold", 32'(underflow_sticky), 32'd1);

    // Row 3 before reset; the first pixel after reset must use BAYER4[0][0]
    step("rm0", P81, 1, 1, 1, O0,  0, 1, 1);
    step("rm1", P81, 1, 1, 1, O20, 1, 1, 1);
    reset = 1'b1;
    step("rm2", P81, 1, 0, 1, O0, 0, 1, 1);
    check("rm2.sticky", 32'(underflow_sticky), 32'd0);
    reset = 1'b0;
    step("rm3", P81, 1, 1, 1, O0,  0, 1, 1);
    step("rm4", 24'h0, 0, 1, 1, O21, 1, 1, 1);
    step("rm5", 24'h0, 0, 1, 1, O0,  0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
